// File: rtl/aes_result_drain.sv
// Captures vector stores to a fixed address into a block FIFO and drains them as 32-bit words.
// Latency: a block captured into an empty FIFO presents word 0 with out_valid=1 right after the capture edge.
// Backpressure: out_ready=0 holds the current word; when full, a capture is dropped (sticky ovf) unless a pop frees a slot that same cycle.
module aes_result_drain #(
  parameter int          VLEN  = 128,
  parameter int          DEPTH = 4,
  parameter logic [31:0] BASE  = 32'h0000_0F00
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [31:0]                  addr,
  input  logic [VLEN-1:0]              din,
  input  logic [3:0]                   wmem,
  input  logic                         vector,
  output logic [31:0]                  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int WORDS = VLEN / 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [VLEN-1:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WW-1:0]     word_idx;
  logic [CW-1:0]     count_nxt;
  logic [31:0]       head_word;

  // armed is low for the first edge after reset release, so a store that
  // happens to sit on the bus as clr drops is not captured.
  logic              armed;
  logic              capture;
  logic              full;
  logic              last_word;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              drop;

  // Pointer increment with explicit wrap so non-power-of-two DEPTH works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign capture   = armed && vector && (wmem != 4'b0000) && (addr == BASE);
  assign last_word = (word_idx == WW'(WORDS - 1));
  assign xfer      = (state == SEND) && out_ready;
  assign pop       = xfer && last_word;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Arm capture one edge after reset release.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Block storage; contents are don't-care until written, output is gated by state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_nxt;
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Word index within the head block; holds while stalled, wraps on the last word.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      word_idx <= '0;
    end else if (xfer) begin
      word_idx <= last_word ? '0 : word_idx + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (push) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = last_word;
        if (pop && !push && (count == CW'(1))) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the current word from the head block; forced to zero when not valid.
  always_comb begin
    head_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (word_idx == WW'(k)) begin
        head_word = mem[rd_ptr][32*k +: 32];
      end
    end
    out_data = out_valid ? head_word : 32'h0;
  end

endmodule

// File: tb/tb_aes_result_drain.sv
module tb_aes_result_drain;

  localparam logic [31:0] BASE = 32'h0000_0F00;

  logic         clk = 1'b0;
  logic         clr;
  logic [31:0]  addr;
  logic [127:0] din;
  logic [3:0]   wmem;
  logic         vector;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   count;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  aes_result_drain #(.VLEN(128), .DEPTH(4), .BASE(BASE)) dut (
    .clk       (clk),
    .clr       (clr),
    .addr      (addr),
    .din       (din),
    .wmem      (wmem),
    .vector    (vector),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vec;
    logic [3:0]   wm;
    logic [31:0]  ad;
    logic [127:0] d;
    logic         rdy;
    logic         ev;
    logic [31:0]  ed;
    logic         el;
    logic [2:0]   ec;
    logic         eo;
  } row_t;

  row_t tbl[16];

  function automatic row_t mk(input logic vec, input logic [3:0] wm, input logic [31:0] ad,
                              input logic [127:0] d, input logic rdy, input logic ev,
                              input logic [31:0] ed, input logic el, input logic [2:0] ec,
                              input logic eo);
    row_t r;
    r.vec = vec; r.wm = wm; r.ad = ad; r.d = d; r.rdy = rdy;
    r.ev = ev; r.ed = ed; r.el = el; r.ec = ec; r.eo = eo;
    return r;
  endfunction

  function automatic logic [127:0] blk(input int i);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      r[32*k +: 32] = 32'hB000_0000 + 32'(i * 256) + 32'(k);
    end
    return r;
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] b, input int k);
    return b[32*k +: 32];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] ed, input logic el);
    chk({nm, " valid"}, 128'(out_valid), 128'(1'b1));
    chk({nm, " data"},  128'(out_data),  128'(ed));
    chk({nm, " last"},  128'(out_last),  128'(el));
  endtask

  task automatic set_idle();
    vector = 1'b0; wmem = 4'h0; addr = 32'h0; din = '0;
  endtask

  task automatic set_store(input logic [127:0] d);
    vector = 1'b1; wmem = 4'hF; addr = BASE; din = d;
  endtask

  // Drain one full block with out_ready=1 already set; checks each word before its edge.
  task automatic drain_block(input string nm, input logic [127:0] b);
    for (int k = 0; k < 4; k++) begin
      chk_word(nm, wd(b, k), k == 3);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    set_idle();
    out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d1;
    logic [127:0] d2;
    d1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    d2 = 128'hA3A2A1A0_B3B2B1B0_C3C2C1C0_D3D2D1D0;

    // row: inputs for the next edge, outputs expected after that edge
    tbl[0]  = mk(1, 4'hF, BASE,       d1, 1, 1, 32'hCCDDEEFF, 0, 1, 0);
    tbl[1]  = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'h8899AABB, 0, 1, 0);
    tbl[2]  = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'h44556677, 0, 1, 0);
    tbl[3]  = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'h00112233, 1, 1, 0);
    tbl[4]  = mk(0, 4'h0, 32'h0,      '0, 1, 0, 32'h0,        0, 0, 0);
    tbl[5]  = mk(1, 4'hF, BASE + 4,   d1, 1, 0, 32'h0,        0, 0, 0);
    tbl[6]  = mk(0, 4'hF, BASE,       d1, 1, 0, 32'h0,        0, 0, 0);
    tbl[7]  = mk(1, 4'h0, BASE,       d1, 1, 0, 32'h0,        0, 0, 0);
    tbl[8]  = mk(1, 4'h1, BASE,       d2, 0, 1, 32'hD3D2D1D0, 0, 1, 0);
    tbl[9]  = mk(0, 4'h0, 32'h0,      '0, 0, 1, 32'hD3D2D1D0, 0, 1, 0);
    tbl[10] = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'hC3C2C1C0, 0, 1, 0);
    tbl[11] = mk(0, 4'h0, 32'h0,      '0, 0, 1, 32'hC3C2C1C0, 0, 1, 0);
    tbl[12] = mk(0, 4'h0, 32'h0,      '0, 0, 1, 32'hC3C2C1C0, 0, 1, 0);
    tbl[13] = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'hB3B2B1B0, 0, 1, 0);
    tbl[14] = mk(0, 4'h0, 32'h0,      '0, 1, 1, 32'hA3A2A1A0, 1, 1, 0);
    tbl[15] = mk(0, 4'h0, 32'h0,      '0, 1, 0, 32'h0,        0, 0, 0);

    // reset state
    clr = 1'b1;
    set_idle();
    out_ready = 1'b0;
    #3;
    chk("rst valid", 128'(out_valid), 128'(0));
    chk("rst data",  128'(out_data),  128'(0));
    chk("rst last",  128'(out_last),  128'(0));
    chk("rst count", 128'(count),     128'(0));
    chk("rst ovf",   128'(ovf),       128'(0));
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // table: single block, ignored stores, partial wmem, stalls
    for (int i = 0; i < 16; i++) begin
      vector = tbl[i].vec; wmem = tbl[i].wm; addr = tbl[i].ad;
      din = tbl[i].d; out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("row%0d data", i),  128'(out_data),  128'(tbl[i].ed));
      chk($sformatf("row%0d last", i),  128'(out_last),  128'(tbl[i].el));
      chk($sformatf("row%0d count", i), 128'(count),     128'(tbl[i].ec));
      chk($sformatf("row%0d ovf", i),   128'(ovf),       128'(tbl[i].eo));
    end
    set_idle();

    // overflow: five stores while stalled, the fifth is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_store(blk(i));
      @(negedge clk);
    end
    set_idle();
    chk("ovf count", 128'(count), 128'(4));
    chk("ovf flag",  128'(ovf),   128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drain_block($sformatf("ovf blk%0d", i), blk(i));
    end
    chk("ovf drained valid", 128'(out_valid), 128'(0));
    chk("ovf drained count", 128'(count),     128'(0));
    chk("ovf sticky",        128'(ovf),       128'(1));

    do_reset();
    chk("ovf cleared", 128'(ovf), 128'(0));

    // full FIFO, push coincides with last-word pop
    for (int i = 0; i < 4; i++) begin
      set_store(blk(10 + i));
      @(negedge clk);
    end
    set_idle();
    chk("full count", 128'(count), 128'(4));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_word("full blk10", wd(blk(10), k), k == 3);
      if (k == 3) set_store(blk(14));
      @(negedge clk);
    end
    set_idle();
    chk("full swap count", 128'(count), 128'(4));
    chk("full swap ovf",   128'(ovf),   128'(0));
    for (int i = 1; i < 5; i++) begin
      drain_block($sformatf("full blk%0d", 10 + i), blk(10 + i));
    end
    chk("full drained count", 128'(count), 128'(0));
    chk("full drained ovf",   128'(ovf),   128'(0));

    // reset mid-block, then capture suppressed on the release edge
    set_store(blk(20));
    @(negedge clk);
    set_idle();
    chk_word("mid w0", wd(blk(20), 0), 1'b0);
    @(negedge clk);
    chk_word("mid w1", wd(blk(20), 1), 1'b0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr valid", 128'(out_valid), 128'(0));
    chk("clr count", 128'(count),     128'(0));
    chk("clr data",  128'(out_data),  128'(0));
    chk("clr last",  128'(out_last),  128'(0));
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    set_store(blk(21));
    @(negedge clk);
    chk("release ignored count", 128'(count),     128'(0));
    chk("release ignored valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    set_idle();
    chk("after clr count", 128'(count), 128'(1));
    out_ready = 1'b1;
    drain_block("after clr blk21", blk(21));
    chk("after clr empty valid", 128'(out_valid), 128'(0));
    chk("after clr empty count", 128'(count),     128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_result_drain.md
AES_RESULT_DRAIN -- requirements
Module: aes_result_drain

Interface
REQ-001 Parameter VLEN, default 128, SHALL set the vector store data width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set FIFO capacity in VLEN-bit blocks.
REQ-003 Parameter BASE, default 32'h0000_0F00, SHALL set the capture address.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 clr  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 addr  input  32  SHALL carry the store address (low 32 bits of the CPU data-memory address bus).
REQ-007 din  input  VLEN  SHALL carry the store data (CPU store-data bus).
REQ-008 wmem  input  4  SHALL carry the CPU byte write enables.
REQ-009 vector  input  1  SHALL flag the current store as a vector store.
REQ-010 out_data  output  32  SHALL carry the current outgoing word.
REQ-011 out_valid  output  1  SHALL indicate that out_data holds a valid word.
REQ-012 out_ready  input  1  SHALL indicate that the consumer accepts out_data this cycle.
REQ-013 out_last  output  1  SHALL mark the final word of a block.
REQ-014 count  output  $clog2(DEPTH+1)  SHALL give the number of blocks held, including any block partly sent.
REQ-015 ovf  output  1  SHALL be a sticky flag indicating a block was dropped.

Function
REQ-016 Capture condition: vector=1, wmem!=4'b0000 and addr==BASE, all sampled at a rising clk edge.
REQ-017 A capture SHALL push the whole din into the FIFO tail. Partial wmem SHALL still store the full VLEN bits.
REQ-018 Non-vector stores and stores to other addresses SHALL be ignored.
REQ-019 Each block SHALL be serialized as VLEN/32 words, least-significant first: word k = din[32k+31:32k].
REQ-020 FSM SHALL have two states, IDLE (count==0) and SEND (count>0). IDLE->SEND on push; SEND->IDLE on the last-word pop when no push occurs in the same cycle and count==1.
REQ-021 out_valid SHALL be 1 exactly in SEND. out_data SHALL be driven from registered FIFO storage and word index only, with no combinational path from din.
REQ-022 A word transfers when out_valid & out_ready. Word index SHALL increment on transfer, from 0 to VLEN/32-1.
REQ-023 out_last SHALL be 1 when out_valid=1 and word index==VLEN/32-1.
REQ-024 A transfer with out_last=1 SHALL pop the head block and reset word index to 0.
REQ-025 out_data and word index SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Latency: a block captured at edge N SHALL present word 0 with out_valid=1 after edge N when the FIFO was empty.
REQ-027 Simultaneous push and pop SHALL leave count unchanged. This holds also when count==DEPTH: the push is accepted into the freed slot.
REQ-028 A push with count==DEPTH and no pop that cycle SHALL be dropped and set ovf=1. ovf SHALL stay 1 until reset.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH. Blocks SHALL emerge in capture order.

Reset
REQ-030 clr=1 SHALL immediately clear the following: count=0, pointers=0, word index=0, ovf=0, out_valid=0, out_last=0, out_data=32'h0, state=IDLE.
REQ-031 Reset during a partly sent block SHALL discard all FIFO content. No further words from that block SHALL be output.
REQ-032 A capture condition present in the same cycle that clr deasserts SHALL be ignored. Capture SHALL resume from the first edge with clr=0 already sampled.

Verification
REQ-033 One store of din=128'h00112233_44556677_8899AABB_CCDDEEFF to BASE with out_ready=1. Required response: words CCDDEEFF, 8899AABB, 44556677, 00112233 on four consecutive cycles, out_last on the 4th, then count=0.
REQ-034 Store to BASE+4, and a vector=0 store to BASE. Required response: count stays 0 and out_valid stays 0.
REQ-035 Five stores with out_ready=0. Required response: count=4, ovf=1, and after out_ready=1 the first four blocks emerge in order.
REQ-036 FIFO full, with a store coinciding with the last-word transfer. Required response: count stays 4, ovf stays 0, and the new block emerges last.
REQ-037 out_ready toggled 1,0,0,1 during a block. Required response: out_data held constant while stalled, no word skipped or duplicated.
REQ-038 clr pulsed after word 1 of a block. Required response: out_valid=0 and count=0 at once, and the next store emits its own word 0 first.
